// File: rtl/jtag_tap_master.sv
// jtag_tap_master
//   Initiator side of a JTAG link. It turns host commands into TCK/TMS/TDI
//   waveforms derived from clk and samples TDO. The four commands are TAP
//   reset, IR scan, DR scan and Run-Test/Idle clocking. Scans assume that the
//   TAP starts and ends in Run-Test/Idle.
//
//   Ports
//     clk, rstn              system clock, asynchronous active-low reset
//     cmd_valid/cmd_ready    command handshake, accepted only in IDLE
//     cmd_type               00 TAP reset, 01 IR scan, 10 DR scan, 11 idle clocks
//     cmd_len                scan bits or idle TCK count, clamped to MAX_LEN
//     cmd_tdi                shift-in data, LSB first
//     rsp_valid              one-cycle completion pulse
//     rsp_tdo                captured TDO bits, LSB first, held until next completion
//     busy                   command in progress
//     tck, tms, tdi, tdo     JTAG pins
//
//   state | meaning
//   IDLE  | waiting for a command, TCK parked low
//   RST   | six TCK with TMS 1,1,1,1,1,0 -> Test-Logic-Reset then Run-Test/Idle
//   PRE   | walk from Run-Test/Idle to Shift-IR (1,1,0,0) or Shift-DR (1,0,0)
//   SHIFT | len data bits, TMS high on the last bit
//   POST  | Exit1 -> Update -> Run-Test/Idle (1,0)
//   RUN   | len TCK with TMS low
module jtag_tap_master #(
   parameter int CLK_DIV = 4,
   parameter int MAX_LEN = 32
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_type,
   input  logic [5:0]         cmd_len,
   input  logic [MAX_LEN-1:0] cmd_tdi,
   output logic               rsp_valid,
   output logic [MAX_LEN-1:0] rsp_tdo,
   output logic               busy,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   input  logic               tdo
);

   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [5:0] LEN_CAP = (MAX_LEN > 63) ? 6'd63 : 6'(MAX_LEN);

   localparam logic [1:0] CMD_RST = 2'b00;
   localparam logic [1:0] CMD_IR  = 2'b01;
   localparam logic [1:0] CMD_DR  = 2'b10;

   typedef enum logic [2:0] {IDLE, RST, PRE, SHIFT, POST, RUN} state_t;

   state_t             state;
   logic [DIV_W-1:0]   div_cnt;
   logic [5:0]         bit_cnt;
   logic [5:0]         len_q;
   logic               is_ir;
   logic [MAX_LEN-1:0] sh_q;
   logic [MAX_LEN-1:0] cap_q;

   logic [5:0]         len_clamp;
   logic [5:0]         bit_nxt;
   logic               last_bit;
   logic [MAX_LEN-1:0] cap_aligned;

   function automatic logic [5:0] phase_len(state_t s, logic [5:0] n, logic ir);
      case (s)
         RST:        phase_len = 6'd6;
         PRE:        phase_len = ir ? 6'd4 : 6'd3;
         SHIFT, RUN: phase_len = n;
         POST:       phase_len = 6'd2;
         default:    phase_len = 6'd1;
      endcase
   endfunction

   // TMS level for bit b of phase s
   function automatic logic tms_at(state_t s, logic [5:0] b, logic [5:0] n, logic ir);
      case (s)
         RST:     tms_at = (b != 6'd5);
         PRE:     tms_at = ir ? (b < 6'd2) : (b == 6'd0);
         SHIFT:   tms_at = (b == n - 6'd1);
         POST:    tms_at = (b == 6'd0);
         default: tms_at = 1'b0;
      endcase
   endfunction

   assign len_clamp = (cmd_len > LEN_CAP) ? LEN_CAP : cmd_len;
   assign bit_nxt   = bit_cnt + 6'd1;
   assign last_bit  = (bit_cnt == phase_len(state, len_q, is_ir) - 6'd1);
   // TDO enters at the MSB, so after len bits the data sits in the top len
   // positions; shifting down right-aligns it and zero-fills the rest.
   assign cap_aligned = cap_q >> (MAX_LEN - int'(len_q));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         len_q     <= '0;
         is_ir     <= 1'b0;
         sh_q      <= '0;
         cap_q     <= '0;
         tck       <= 1'b0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_tdo   <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  len_q   <= len_clamp;
                  is_ir   <= (cmd_type == CMD_IR);
                  sh_q    <= cmd_tdi;
                  cap_q   <= '0;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  tck     <= 1'b0;
                  tdi     <= 1'b0;
                  if (cmd_type != CMD_RST && len_clamp == 6'd0) begin
                     // zero-length scan/idle: no TCK, immediate empty response
                     rsp_valid <= 1'b1;
                     rsp_tdo   <= '0;
                     tms       <= 1'b0;
                  end else begin
                     busy      <= 1'b1;
                     cmd_ready <= 1'b0;
                     case (cmd_type)
                        CMD_RST: begin
                           state <= RST;
                           tms   <= 1'b1;
                        end
                        CMD_IR, CMD_DR: begin
                           state <= PRE;
                           tms   <= 1'b1;
                        end
                        default: begin
                           state <= RUN;
                           tms   <= 1'b0;
                        end
                     endcase
                  end
               end
            end
            default: begin
               div_cnt <= div_cnt + 1'b1;
               if (div_cnt == DIV_RISE) begin
                  tck <= 1'b1;
                  if (state == SHIFT) begin
                     cap_q <= {tdo, cap_q[MAX_LEN-1:1]};
                  end
               end
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  tck     <= 1'b0;
                  if (!last_bit) begin
                     bit_cnt <= bit_nxt;
                     tms     <= tms_at(state, bit_nxt, len_q, is_ir);
                     if (state == SHIFT) begin
                        tdi  <= sh_q[0];
                        sh_q <= sh_q >> 1;
                     end
                  end else begin
                     case (state)
                        PRE: begin
                           state   <= SHIFT;
                           bit_cnt <= '0;
                           tms     <= tms_at(SHIFT, 6'd0, len_q, is_ir);
                           tdi     <= sh_q[0];
                           sh_q    <= sh_q >> 1;
                        end
                        SHIFT: begin
                           state   <= POST;
                           bit_cnt <= '0;
                           tms     <= 1'b1;
                           tdi     <= 1'b0;
                        end
                        default: begin
                           state     <= IDLE;
                           bit_cnt   <= '0;
                           tms       <= 1'b0;
                           tdi       <= 1'b0;
                           busy      <= 1'b0;
                           cmd_ready <= 1'b1;
                           rsp_valid <= 1'b1;
                           rsp_tdo   <= (state == POST) ? cap_aligned : '0;
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule
